// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, exception codes, tlb_op bit indices and MEM->WB payload layout
package wb_stage_pkg;

    localparam int MEM_TO_WB_BUS_W = 211;
    localparam int WB_TO_ID_BUS_W  = 38;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam int TLB_OP_INV  = 0;
    localparam int TLB_OP_RD   = 1;
    localparam int TLB_OP_FILL = 2;
    localparam int TLB_OP_WR   = 3;
    localparam int TLB_OP_SRCH = 4;

    // Field order is the wire order of mem_to_wb_bus, MSB first
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic        read_tid;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        excep_en;
        logic        exc_adef;
        logic        exc_sys;
        logic        exc_ale;
        logic        exc_brk;
        logic        exc_ine;
        logic        exc_int;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic [4:0]  tlb_op;
        logic        srch_conflict;
        logic [4:0]  tlbsrch_res;
    } mem_to_wb_t;

endpackage

// File: rtl/wb_excep_encode.sv
// rtl/wb_excep_encode.sv - priority encoder from exception flags to ecode/esubcode
module wb_excep_encode
    import wb_stage_pkg::*;
(
    input  logic       exc_adef,
    input  logic       exc_sys,
    input  logic       exc_ale,
    input  logic       exc_brk,
    input  logic       exc_ine,
    input  logic       exc_int,
    input  logic [8:0] esubcode_in,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    // Interrupt outranks fetch faults, which outrank decode and execute faults
    always_comb begin
        ecode = ECODE_INT;
        if (exc_int) begin
            ecode = ECODE_INT;
        end else if (exc_adef) begin
            ecode = ECODE_ADEF;
        end else if (exc_ine) begin
            ecode = ECODE_INE;
        end else if (exc_sys) begin
            ecode = ECODE_SYS;
        end else if (exc_brk) begin
            ecode = ECODE_BRK;
        end else if (exc_ale) begin
            ecode = ECODE_ALE;
        end
    end

    assign esubcode = esubcode_in;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: RF/CSR/TLB commit, exception commit, flush; optional trace ports under WB_DEBUG_TRACE_EN
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mem_to_wb_valid,
    input  logic [MEM_TO_WB_BUS_W-1:0] mem_to_wb_bus,
    output logic                       wb_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [WB_TO_ID_BUS_W-1:0]  wb_to_id_bus,
    output logic                       csr_re,
    output logic [13:0]                csr_num,
    input  logic [31:0]                csr_rvalue,
    output logic                       csr_we,
    output logic [31:0]                csr_wmask,
    output logic [31:0]                csr_wvalue,
    output logic                       wb_ex,
    output logic [5:0]                 wb_ecode,
    output logic [8:0]                 wb_esubcode,
    output logic [31:0]                wb_pc,
    output logic [31:0]                wb_vaddr,
    output logic                       ertn_flush,
    output logic                       flush,
    output logic [31:0]                refetch_pc,
    output logic                       tlb_we,
    output logic                       tlb_fill,
    output logic                       tlb_rd,
    output logic                       tlb_srch_we,
    output logic [4:0]                 tlbsrch_res,
    input  logic [31:0]                tid_value
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
`endif
);

    logic        wb_valid;
    logic        wb_ready_go;
    logic        wb_live;
    logic        wb_commit;
    mem_to_wb_t  pl;
    logic [4:0]  tlbsrch_q;
    logic        unused_bits;

    assign wb_ready_go = 1'b1;
    assign wb_allowin  = ~wb_valid | wb_ready_go;

    // A held instruction may only touch architectural state while reset is released
    assign wb_live   = wb_valid & resetn;
    assign wb_commit = wb_live & ~pl.excep_en;

    // Stage valid: flush retires the current instruction and drops whatever arrives with it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid <= mem_to_wb_valid;
        end
    end

    // Payload register captures a new instruction on every accepted handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pl <= '0;
        end else if (mem_to_wb_valid & wb_allowin) begin
            pl <= mem_to_wb_bus;
        end
    end

    // TLBSRCH result is architecturally visible until the next committed search
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tlbsrch_q <= '0;
        end else if (tlb_srch_we) begin
            tlbsrch_q <= pl.tlbsrch_res;
        end
    end

    // Register-file write data: rdcntid beats csrrd beats the ALU/load result
    always_comb begin
        rf_wdata = pl.rf_wdata;
        if (pl.read_tid) begin
            rf_wdata = tid_value;
        end else if (pl.csr_re) begin
            rf_wdata = csr_rvalue;
        end
    end

    assign rf_we        = wb_live & pl.rf_we & ~pl.excep_en;
    assign rf_waddr     = pl.rf_waddr;
    assign wb_to_id_bus = {pl.rf_we & wb_valid, pl.rf_waddr, rf_wdata};

    assign csr_re     = wb_commit & pl.csr_re;
    assign csr_num    = pl.csr_num;
    assign csr_we     = wb_commit & pl.csr_we;
    assign csr_wmask  = pl.csr_wmask;
    assign csr_wvalue = pl.csr_wvalue;

    assign wb_ex      = wb_live & pl.excep_en;
    assign wb_pc      = pl.pc;
    assign wb_vaddr   = pl.vaddr;
    assign ertn_flush = wb_commit & pl.ertn;

    assign tlb_we      = wb_commit & pl.tlb_op[TLB_OP_WR];
    assign tlb_fill    = wb_commit & pl.tlb_op[TLB_OP_FILL];
    assign tlb_rd      = wb_commit & pl.tlb_op[TLB_OP_RD];
    assign tlb_srch_we = wb_commit & pl.tlb_op[TLB_OP_SRCH];
    assign tlbsrch_res = tlbsrch_q & {5{resetn}};

    assign flush      = wb_live & (pl.excep_en | pl.ertn | (|pl.tlb_op[3:0]));
    assign refetch_pc = pl.pc + 32'd4;

    // Search-conflict status is consumed by the CSR file elsewhere, not by this stage
    assign unused_bits = pl.srch_conflict;

    wb_excep_encode u_excep_encode (
        .exc_adef    (pl.exc_adef & wb_live),
        .exc_sys     (pl.exc_sys  & wb_live),
        .exc_ale     (pl.exc_ale  & wb_live),
        .exc_brk     (pl.exc_brk  & wb_live),
        .exc_ine     (pl.exc_ine  & wb_live),
        .exc_int     (pl.exc_int  & wb_live),
        .esubcode_in (pl.esubcode),
        .ecode       (wb_ecode),
        .esubcode    (wb_esubcode)
    );

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pl.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = pl.rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;

    typedef struct {
        bit        rf_we;
        bit [4:0]  waddr;
        bit [31:0] wdata;
        bit [31:0] pc;
        bit        read_tid;
        bit        csr_re;
        bit        csr_we;
        bit [13:0] csr_num;
        bit [31:0] wmask;
        bit [31:0] wvalue;
        bit        ertn;
        bit        excep_en;
        bit        adef, sys, ale, brk, ine, intr;
        bit [8:0]  esub;
        bit [31:0] vaddr;
        bit [4:0]  tlb_op;
        bit        conflict;
        bit [4:0]  sres;
    } instr_t;

    logic         clk;
    logic         resetn;
    logic         mem_to_wb_valid;
    logic [210:0] mem_to_wb_bus;
    logic         wb_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [37:0]  wb_to_id_bus;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         wb_ex;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [31:0]  wb_pc;
    logic [31:0]  wb_vaddr;
    logic         ertn_flush;
    logic         flush;
    logic [31:0]  refetch_pc;
    logic         tlb_we;
    logic         tlb_fill;
    logic         tlb_rd;
    logic         tlb_srch_we;
    logic [4:0]   tlbsrch_res;
    logic [31:0]  tid_value;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: the instruction WB holds, whether it is valid, last search result
    instr_t    m_held;
    bit        m_valid;
    bit [4:0]  m_tlbsrch;
    instr_t    m_in;
    bit        m_in_v;

    wb_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .wb_allowin      (wb_allowin),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .wb_to_id_bus    (wb_to_id_bus),
        .csr_re          (csr_re),
        .csr_num         (csr_num),
        .csr_rvalue      (csr_rvalue),
        .csr_we          (csr_we),
        .csr_wmask       (csr_wmask),
        .csr_wvalue      (csr_wvalue),
        .wb_ex           (wb_ex),
        .wb_ecode        (wb_ecode),
        .wb_esubcode     (wb_esubcode),
        .wb_pc           (wb_pc),
        .wb_vaddr        (wb_vaddr),
        .ertn_flush      (ertn_flush),
        .flush           (flush),
        .refetch_pc      (refetch_pc),
        .tlb_we          (tlb_we),
        .tlb_fill        (tlb_fill),
        .tlb_rd          (tlb_rd),
        .tlb_srch_we     (tlb_srch_we),
        .tlbsrch_res     (tlbsrch_res),
        .tid_value       (tid_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [210:0] pack(input instr_t i);
        return {i.rf_we, i.waddr, i.wdata, i.pc, i.read_tid,
                i.csr_re, i.csr_we, i.csr_num, i.wmask, i.wvalue,
                i.ertn, i.excep_en, i.adef, i.sys, i.ale, i.brk, i.ine, i.intr, i.esub, i.vaddr,
                i.tlb_op, i.conflict, i.sres};
    endfunction

    function automatic logic [5:0] exp_ecode(input instr_t i, input bit live);
        if (!live)  return 6'h00;
        if (i.intr) return 6'h00;
        if (i.adef) return 6'h08;
        if (i.ine)  return 6'h0D;
        if (i.sys)  return 6'h0B;
        if (i.brk)  return 6'h0C;
        if (i.ale)  return 6'h09;
        return 6'h00;
    endfunction

    function automatic instr_t blank();
        instr_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i          = blank();
        i.rf_we    = 1'($urandom_range(0, 1));
        i.waddr    = 5'($urandom);
        i.wdata    = $urandom;
        i.pc       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        i.read_tid = ($urandom_range(0, 7) == 0);
        i.csr_re   = ($urandom_range(0, 5) == 0);
        i.csr_we   = ($urandom_range(0, 5) == 0);
        i.csr_num  = 14'($urandom);
        i.wmask    = $urandom;
        i.wvalue   = $urandom;
        i.ertn     = ($urandom_range(0, 9) == 0);
        i.excep_en = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1) begin
            {i.adef, i.sys, i.ale, i.brk, i.ine, i.intr} = 6'($urandom);
        end
        i.esub     = 9'($urandom);
        i.vaddr    = $urandom;
        if ($urandom_range(0, 4) == 0) i.tlb_op = 5'(1 << $urandom_range(0, 4));
        i.conflict = 1'($urandom_range(0, 1));
        i.sres     = 5'($urandom);
        return i;
    endfunction

    task automatic set_in(input bit v, input instr_t i, input bit r);
        mem_to_wb_valid = v;
        mem_to_wb_bus   = pack(i);
        resetn          = r;
        m_in            = i;
        m_in_v          = v;
    endtask

    // Compare every output against what the held instruction implies
    task automatic sample();
        bit live, ex, ok, fl;
        logic [31:0] wd;
        @(negedge clk);
        live = m_valid && resetn;
        ex   = live && m_held.excep_en;
        ok   = live && !m_held.excep_en;
        fl   = live && (m_held.excep_en || m_held.ertn || (m_held.tlb_op[3:0] != 0));
        wd   = m_held.read_tid ? tid_value : (m_held.csr_re ? csr_rvalue : m_held.wdata);
        check("wb_allowin", wb_allowin, 1);
        check("rf_we", rf_we, ok && m_held.rf_we);
        check("rf_waddr", rf_waddr, m_held.waddr);
        check("rf_wdata", rf_wdata, wd);
        check("wb_to_id_bus", wb_to_id_bus, {m_valid && m_held.rf_we, m_held.waddr, wd});
        check("csr_re", csr_re, ok && m_held.csr_re);
        check("csr_num", csr_num, m_held.csr_num);
        check("csr_we", csr_we, ok && m_held.csr_we);
        check("csr_wmask", csr_wmask, m_held.wmask);
        check("csr_wvalue", csr_wvalue, m_held.wvalue);
        check("wb_ex", wb_ex, ex);
        check("wb_ecode", wb_ecode, exp_ecode(m_held, live));
        check("wb_esubcode", wb_esubcode, m_held.esub);
        check("wb_pc", wb_pc, m_held.pc);
        check("wb_vaddr", wb_vaddr, m_held.vaddr);
        check("ertn_flush", ertn_flush, ok && m_held.ertn);
        check("flush", flush, fl);
        check("refetch_pc", refetch_pc, 32'(m_held.pc + 32'd4));
        check("tlb_we", tlb_we, ok && m_held.tlb_op[3]);
        check("tlb_fill", tlb_fill, ok && m_held.tlb_op[2]);
        check("tlb_rd", tlb_rd, ok && m_held.tlb_op[1]);
        check("tlb_srch_we", tlb_srch_we, ok && m_held.tlb_op[4]);
        check("tlbsrch_res", tlbsrch_res, resetn ? m_tlbsrch : 5'd0);
    endtask

    task automatic advance();
        bit fl;
        @(posedge clk);
        if (!resetn) begin
            m_valid   = 0;
            m_tlbsrch = 0;
            m_held    = blank();
        end else begin
            fl = m_valid && (m_held.excep_en || m_held.ertn || (m_held.tlb_op[3:0] != 0));
            if (m_valid && !m_held.excep_en && m_held.tlb_op[4]) m_tlbsrch = m_held.sres;
            if (m_in_v) m_held = m_in;
            m_valid = fl ? 0 : m_in_v;
        end
        #1;
    endtask

    initial begin
        instr_t i;
        int commits;
        m_held     = blank();
        m_valid    = 0;
        m_tlbsrch  = 0;
        csr_rvalue = 32'h0;
        tid_value  = 32'h0;
        set_in(0, blank(), 0);
        advance();
        advance();

        // Reset state
        sample();
        check("rst_rf_we", rf_we, 0);
        check("rst_flush", flush, 0);
        check("rst_ecode", wb_ecode, 0);
        check("rst_tlbsrch", tlbsrch_res, 0);
        check("rst_allowin", wb_allowin, 1);
        check("rst_csr_we", csr_we, 0);
        advance();

        // Plain ALU write to r5
        i = blank(); i.rf_we = 1; i.waddr = 5; i.wdata = 32'h1234; i.pc = 32'h1C00_0000;
        set_in(1, i, 1); sample(); advance();
        set_in(0, blank(), 1); sample();
        check("add_rf_we", rf_we, 1);
        check("add_waddr", rf_waddr, 5);
        check("add_wdata", rf_wdata, 32'h0000_1234);
        check("add_flush", flush, 0);
        advance();

        // csrrd returns the CSR file's read value
        i = blank(); i.rf_we = 1; i.waddr = 7; i.csr_re = 1; i.csr_num = 14'h0C; i.wdata = 32'h5555;
        csr_rvalue = 32'hDEAD_BEEF;
        set_in(1, i, 1); sample(); advance();
        set_in(0, blank(), 1); sample();
        check("csrrd_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("csrrd_csr_we", csr_we, 0);
        check("csrrd_csr_num", csr_num, 14'h0C);
        advance();

        // SYS + ALE together: SYS wins, flush kills the instruction arriving behind it
        i = blank(); i.rf_we = 1; i.excep_en = 1; i.sys = 1; i.ale = 1; i.pc = 32'h1C00_0100;
        set_in(1, i, 1); sample(); advance();
        i = blank(); i.rf_we = 1; i.waddr = 9;
        set_in(1, i, 1); sample();
        check("sys_wb_ex", wb_ex, 1);
        check("sys_ecode", wb_ecode, 6'h0B);
        check("sys_wb_pc", wb_pc, 32'h1C00_0100);
        check("sys_rf_we", rf_we, 0);
        check("sys_flush", flush, 1);
        advance();
        set_in(0, blank(), 1); sample();
        check("sys_valid_next", dut.wb_valid, 0);
        check("sys_rf_we_next", rf_we, 0);
        advance();

        // tlbwr refetches at pc+4, including 32-bit wrap
        i = blank(); i.tlb_op = 5'b01000; i.pc = 32'h1C00_0200;
        set_in(1, i, 1); sample(); advance();
        set_in(0, blank(), 1); sample();
        check("tlbwr_we", tlb_we, 1);
        check("tlbwr_flush", flush, 1);
        check("tlbwr_refetch", refetch_pc, 32'h1C00_0204);
        advance();
        i.pc = 32'hFFFF_FFFC;
        set_in(1, i, 1); sample(); advance();
        set_in(0, blank(), 1); sample();
        check("tlbwr_refetch_wrap", refetch_pc, 32'h0000_0000);
        advance();

        // ertn with a pending exception commits only the exception
        i = blank(); i.ertn = 1; i.excep_en = 1; i.ine = 1;
        set_in(1, i, 1); sample(); advance();
        set_in(0, blank(), 1); sample();
        check("ertn_ex_flush", ertn_flush, 0);
        check("ertn_ex_wb_ex", wb_ex, 1);
        advance();

        // Eight back-to-back instructions commit on eight consecutive cycles
        commits = 0;
        for (int k = 0; k <= 8; k++) begin
            i = blank(); i.rf_we = 1; i.waddr = 5'(k + 1); i.wdata = 32'(k * 3);
            set_in(k < 8, i, 1); sample();
            if (k >= 1) begin
                check("b2b_rf_we", rf_we, 1);
                check("b2b_waddr", rf_waddr, 5'(k));
                if (rf_we) commits++;
            end
            advance();
        end
        check("b2b_commits", commits, 8);

        // Same stream with reset pulled in cycle 4: nothing commits that cycle or after
        for (int k = 0; k <= 5; k++) begin
            i = blank(); i.rf_we = 1; i.csr_we = 1; i.tlb_op = (k == 3) ? 5'b00100 : 5'b0; i.waddr = 5'(k + 1);
            set_in(k < 5, i, k != 4); sample();
            if (k == 4) begin
                check("rstmid_rf_we", rf_we, 0);
                check("rstmid_csr_we", csr_we, 0);
                check("rstmid_tlb_fill", tlb_fill, 0);
                check("rstmid_flush", flush, 0);
            end
            if (k == 5) check("rstmid_after_rf_we", rf_we, 0);
            advance();
        end

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 2000; n++) begin
            csr_rvalue = $urandom;
            tid_value  = $urandom;
            set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 63) != 0);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
